// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one combinational ALU among NREQ requesters
// Result and flags land in a one-entry response register tagged with the requester index.
module alu_arbiter #(
   parameter int NREQ = 2,
   parameter int IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [3*NREQ-1:0]    req_ctrl,
   input  logic [32*NREQ-1:0]   req_a,
   input  logic [32*NREQ-1:0]   req_b,
   output logic [2:0]           alu_ctrl,
   output logic [31:0]          alu_a,
   output logic [31:0]          alu_b,
   input  logic [31:0]          alu_result,
   input  logic [3:0]           alu_flags,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDW-1:0]       rsp_id,
   output logic [31:0]          rsp_result,
   output logic [3:0]           rsp_flags,
   output logic                 rsp_err
);

   logic [IDW-1:0]  ptr;
   logic [IDW-1:0]  hi_id;
   logic [IDW-1:0]  lo_id;
   logic [IDW-1:0]  gnt_id;
   logic            hi_any;
   logic            lo_any;
   logic            gnt_any;
   logic [NREQ-1:0] grant;
   logic            space;
   logic            accept;
   logic            illegal;

   // Lowest valid index at or above ptr wins; otherwise wrap to the lowest valid index.
   always_comb begin
      hi_any = 1'b0;
      hi_id  = '0;
      lo_any = 1'b0;
      lo_id  = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            lo_any = 1'b1;
            lo_id  = IDW'(i);
            if (i >= int'(ptr)) begin
               hi_any = 1'b1;
               hi_id  = IDW'(i);
            end
         end
      end
      gnt_any = hi_any | lo_any;
      gnt_id  = hi_any ? hi_id : lo_id;
   end

   always_comb begin
      grant = '0;
      if (gnt_any) begin
         grant = NREQ'(1) << gnt_id;
      end
   end

   assign space     = ~rsp_valid | rsp_ready;
   assign accept    = gnt_any & space & reset_n;
   assign req_ready = grant & {NREQ{space & reset_n}};

   // AND-OR operand mux; all-zero drive when nothing is granted.
   always_comb begin
      alu_ctrl = '0;
      alu_a    = '0;
      alu_b    = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            alu_ctrl = alu_ctrl | req_ctrl[3*i +: 3];
            alu_a    = alu_a    | req_a[32*i +: 32];
            alu_b    = alu_b    | req_b[32*i +: 32];
         end
      end
   end

   assign illegal = (alu_ctrl > 3'd4);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ptr        <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_result <= '0;
         rsp_flags  <= '0;
         rsp_err    <= 1'b0;
      end else if (accept) begin
         rsp_valid <= 1'b1;
         rsp_id    <= gnt_id;
         ptr       <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
         if (illegal) begin
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b1;
         end else begin
            rsp_result <= alu_result;
            rsp_flags  <= alu_flags;
            rsp_err    <= 1'b0;
         end
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter (NREQ=2 and NREQ=4)
module tb_alu_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [3:0]  v;
   logic        rdy;
   logic [2:0]  c [4];
   logic [31:0] a [4];
   logic [31:0] b [4];

   logic [11:0]  ctrl_bus;
   logic [127:0] a_bus;
   logic [127:0] b_bus;
   assign ctrl_bus = {c[3], c[2], c[1], c[0]};
   assign a_bus    = {a[3], a[2], a[1], a[0]};
   assign b_bus    = {b[3], b[2], b[1], b[0]};

   logic [1:0]  ready2;
   logic [2:0]  actrl2;
   logic [31:0] aa2, ab2, ares2, rres2;
   logic [3:0]  afl2, rfl2;
   logic        rv2, rerr2;
   logic [0:0]  rid2;

   logic [3:0]  ready4;
   logic [2:0]  actrl4;
   logic [31:0] aa4, ab4, ares4, rres4;
   logic [3:0]  afl4, rfl4;
   logic        rv4, rerr4;
   logic [1:0]  rid4;

   // Reference ALU: flags {N,Z,C,V}, carry on SUB means no borrow.
   function automatic logic [35:0] alu(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
      logic [32:0] s;
      logic [31:0] r;
      logic        cy, ov;
      cy = 1'b0;
      ov = 1'b0;
      s  = '0;
      r  = '0;
      case (op)
         3'd0: begin
            s  = {1'b0, x} + {1'b0, y};
            r  = s[31:0];
            cy = s[32];
            ov = (x[31] == y[31]) && (r[31] != x[31]);
         end
         3'd1: begin
            s  = {1'b0, x} + {1'b0, ~y} + 33'd1;
            r  = s[31:0];
            cy = s[32];
            ov = (x[31] != y[31]) && (r[31] != x[31]);
         end
         3'd2: r = x & y;
         3'd3: r = x | y;
         3'd4: r = x ^ y;
         default: return {4'hF, 32'hDEADBEEF};
      endcase
      return {r[31], (r == 32'd0), cy, ov, r};
   endfunction

   assign {afl2, ares2} = alu(actrl2, aa2, ab2);
   assign {afl4, ares4} = alu(actrl4, aa4, ab4);

   alu_arbiter #(.NREQ(2)) u_dut2 (
      .clk(clk), .reset_n(rst_n),
      .req_valid(v[1:0]), .req_ready(ready2),
      .req_ctrl(ctrl_bus[5:0]), .req_a(a_bus[63:0]), .req_b(b_bus[63:0]),
      .alu_ctrl(actrl2), .alu_a(aa2), .alu_b(ab2),
      .alu_result(ares2), .alu_flags(afl2),
      .rsp_valid(rv2), .rsp_ready(rdy), .rsp_id(rid2),
      .rsp_result(rres2), .rsp_flags(rfl2), .rsp_err(rerr2)
   );

   alu_arbiter #(.NREQ(4)) u_dut4 (
      .clk(clk), .reset_n(rst_n),
      .req_valid(v), .req_ready(ready4),
      .req_ctrl(ctrl_bus), .req_a(a_bus), .req_b(b_bus),
      .alu_ctrl(actrl4), .alu_a(aa4), .alu_b(ab4),
      .alu_result(ares4), .alu_flags(afl4),
      .rsp_valid(rv4), .rsp_ready(rdy), .rsp_id(rid4),
      .rsp_result(rres4), .rsp_flags(rfl4), .rsp_err(rerr4)
   );

   logic [3:0]  o_ready [2];
   logic [2:0]  o_ctrl  [2];
   logic [31:0] o_a     [2];
   logic [31:0] o_b     [2];
   logic        o_rv    [2];
   logic [1:0]  o_id    [2];
   logic [31:0] o_res   [2];
   logic [3:0]  o_fl    [2];
   logic        o_err   [2];
   assign o_ready[0] = {2'b00, ready2};
   assign o_ready[1] = ready4;
   assign o_ctrl[0] = actrl2;
   assign o_ctrl[1] = actrl4;
   assign o_a[0] = aa2;
   assign o_a[1] = aa4;
   assign o_b[0] = ab2;
   assign o_b[1] = ab4;
   assign o_rv[0] = rv2;
   assign o_rv[1] = rv4;
   assign o_id[0] = {1'b0, rid2};
   assign o_id[1] = rid4;
   assign o_res[0] = rres2;
   assign o_res[1] = rres4;
   assign o_fl[0] = rfl2;
   assign o_fl[1] = rfl4;
   assign o_err[0] = rerr2;
   assign o_err[1] = rerr4;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model state per instance (0: NREQ=2, 1: NREQ=4).
   int          m_ptr [2];
   logic        m_rv  [2];
   logic [1:0]  m_id  [2];
   logic [31:0] m_res [2];
   logic [3:0]  m_fl  [2];
   logic        m_err [2];
   bit          armed = 1'b0;

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         automatic int         n  = (k == 0) ? 2 : 4;
         automatic int         g  = -1;
         automatic logic [3:0] er = 4'b0000;
         automatic logic       sp;
         automatic logic [2:0] ec = 3'd0;
         automatic logic [31:0] ea = 32'd0;
         automatic logic [31:0] eb = 32'd0;
         for (int j = 0; j < n; j++) begin
            automatic int idx = (m_ptr[k] + j) % n;
            if (g < 0 && v[idx[1:0]]) g = idx;
         end
         sp = !m_rv[k] || rdy;
         if (g >= 0) begin
            ec = c[g[1:0]];
            ea = a[g[1:0]];
            eb = b[g[1:0]];
            if (sp && rst_n) er[g[1:0]] = 1'b1;
         end
         if (armed) begin
            check($sformatf("m%0d req_ready", k), o_ready[k], er);
            check($sformatf("m%0d alu_ctrl", k), o_ctrl[k], ec);
            check($sformatf("m%0d alu_a", k), o_a[k], ea);
            check($sformatf("m%0d alu_b", k), o_b[k], eb);
            check($sformatf("m%0d rsp_valid", k), o_rv[k], m_rv[k]);
            check($sformatf("m%0d rsp_id", k), o_id[k], m_id[k]);
            check($sformatf("m%0d rsp_result", k), o_res[k], m_res[k]);
            check($sformatf("m%0d rsp_flags", k), o_fl[k], m_fl[k]);
            check($sformatf("m%0d rsp_err", k), o_err[k], m_err[k]);
         end
         if (!rst_n) begin
            m_ptr[k] = 0;
            m_rv[k]  = 1'b0;
            m_id[k]  = 2'd0;
            m_res[k] = 32'd0;
            m_fl[k]  = 4'd0;
            m_err[k] = 1'b0;
         end else if (er != 4'b0000) begin
            m_rv[k] = 1'b1;
            m_id[k] = g[1:0];
            if (ec > 3'd4) begin
               m_res[k] = 32'd0;
               m_fl[k]  = 4'd0;
               m_err[k] = 1'b1;
            end else begin
               {m_fl[k], m_res[k]} = alu(ec, ea, eb);
               m_err[k] = 1'b0;
            end
            m_ptr[k] = (g + 1) % n;
         end else if (m_rv[k] && rdy) begin
            m_rv[k] = 1'b0;
         end
      end
      if (!rst_n) armed = 1'b1;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   logic [0:0] prev_id, want_id, snap_id;
   logic [31:0] snap_res;
   logic [3:0]  snap_fl;
   int          seq [8];
   int          count;

   initial begin
      rst_n = 1'b0;
      v     = 4'b0000;
      rdy   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         c[i] = 3'd0;
         a[i] = 32'd0;
         b[i] = 32'd0;
      end
      repeat (2) cyc();
      check("reset rsp_valid n2", rv2, 1'b0);
      check("reset rsp_valid n4", rv4, 1'b0);
      rst_n = 1'b1;

      // Single ADD with signed overflow
      c[0] = 3'd0; a[0] = 32'h7FFF_FFFF; b[0] = 32'd1;
      v = 4'b0001;
      #1;
      check("t1 req_ready", ready2, 2'b01);
      cyc();
      v = 4'b0000;
      check("t1 rsp_valid", rv2, 1'b1);
      check("t1 rsp_id", rid2, 1'b0);
      check("t1 rsp_result", rres2, 32'h8000_0000);
      check("t1 rsp_flags", rfl2, 4'b1001);
      cyc();
      check("t1 drained", rv2, 1'b0);

      // Round-robin at full rate
      c[0] = 3'd1; a[0] = 32'd5;  b[0] = 32'd5;
      c[1] = 3'd3; a[1] = 32'hF0; b[1] = 32'h0F;
      v = 4'b0011;
      prev_id = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("t2 rsp_valid", rv2, 1'b1);
         if (rid2 == 1'b0) begin
            check("t2 id0 result", rres2, 32'd0);
            check("t2 id0 flags", rfl2, 4'b0110);
         end else begin
            check("t2 id1 result", rres2, 32'hFF);
            check("t2 id1 flags", rfl2, 4'b0000);
         end
         if (i > 0) begin
            want_id = ~prev_id;
            check("t2 id alternates", rid2, want_id);
         end
         prev_id = rid2;
      end

      // Backpressure for 3 cycles, then replacement without a bubble
      rdy = 1'b0;
      snap_id  = rid2;
      snap_res = rres2;
      snap_fl  = rfl2;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("t3 stall ready", ready2, 2'b00);
         cyc();
         check("t3 hold valid", rv2, 1'b1);
         check("t3 hold id", rid2, snap_id);
         check("t3 hold result", rres2, snap_res);
         check("t3 hold flags", rfl2, snap_fl);
      end
      rdy = 1'b1;
      #1;
      check("t3 resume ready", ready2, (snap_id == 1'b0) ? 2'b10 : 2'b01);
      cyc();
      want_id = ~snap_id;
      check("t3 replaced valid", rv2, 1'b1);
      check("t3 replaced id", rid2, want_id);

      // Illegal ALUControl, then a legal one
      v = 4'b0010;
      c[1] = 3'b110; a[1] = 32'd3; b[1] = 32'd4;
      cyc();
      check("t4 err", rerr2, 1'b1);
      check("t4 result", rres2, 32'd0);
      check("t4 flags", rfl2, 4'b0000);
      check("t4 id", rid2, 1'b1);
      v = 4'b0001;
      c[0] = 3'd0; a[0] = 32'd2; b[0] = 32'd3;
      cyc();
      check("t4 legal err", rerr2, 1'b0);
      check("t4 legal id", rid2, 1'b0);
      check("t4 legal result", rres2, 32'd5);

      // Reset while a response is held and both requesters are valid
      v = 4'b0011;
      rdy = 1'b0;
      cyc();
      check("t5 held valid", rv2, 1'b1);
      rst_n = 1'b0;
      #1;
      check("t5 ready in reset n2", ready2, 2'b00);
      check("t5 ready in reset n4", ready4, 4'b0000);
      cyc();
      check("t5 rsp_valid", rv2, 1'b0);
      check("t5 rsp_id", rid2, 1'b0);
      check("t5 rsp_result", rres2, 32'd0);
      check("t5 rsp_flags", rfl2, 4'b0000);
      check("t5 rsp_err", rerr2, 1'b0);
      check("t5 rsp_valid n4", rv4, 1'b0);
      rst_n = 1'b1;
      rdy = 1'b1;
      #1;
      check("t5 first grant", ready2, 2'b01);
      cyc();
      check("t5 first id", rid2, 1'b0);

      // Fairness on NREQ=4 with random stalls
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      c[2] = 3'd2; a[2] = 32'hFF00; b[2] = 32'h0FF0;
      c[3] = 3'd4; a[3] = 32'hAAAA; b[3] = 32'h5555;
      v = 4'b1111;
      count = 0;
      for (int i = 0; i < 8; i++) seq[i] = -1;
      for (int cy = 0; cy < 200 && count < 8; cy++) begin
         rdy = 1'($urandom_range(0, 1));
         #1;
         if (ready4 != 4'b0000) begin
            for (int j = 0; j < 4; j++) begin
               if (ready4[j]) seq[count] = j;
            end
            count++;
         end
         cyc();
      end
      check("t6 accept count", count, 8);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("t6 grant %0d", i), seq[i], i % 4);
      end

      v = 4'b0000;
      rdy = 1'b1;
      repeat (3) cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
